keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the seven-segment digit multiplexer: scans a 4x4 matrix keypad by time-division driving of columns and reading of rows.
- Drives one column low at a time, samples the active-low rows, debounces over whole scan frames, and reports a single debounced key code.
- Sits between the board keypad pins and the communication/display logic.

Parameters:
- TICK_DIV, 65536, clock cycles per column step; minimum 2.
- DEBOUNCE, 4, consecutive identical scan frames required to accept a press or a release; minimum 1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- row  input  4  keypad rows, active-low, asynchronous pins.
- column  output  4  keypad column drive, one-cold, active-low.
- key_code  output  4  {col_idx[1:0], row_idx[1:0]} of last accepted key.
- key_valid  output  1  one-clock pulse when a press is accepted.
- key_down  output  1  level, high while the accepted key is held.
- multi_key  output  1  level, high if the last completed frame saw more than one pressed position.

Behaviour:
- Reset (reset==0 at a clock edge) forces:
  - column=4'b0111, key_code=0, key_valid=0, key_down=0, multi_key=0.
  - Prescaler=0, synchronizer flops=4'hF, FSM=IDLE, counters=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle where count==TICK_DIV-1.
- Row sync: two-flop synchronizer on row. The synchronized value is sampled only on tick, before column advances.
- Column rotation on tick: column <= {column[0], column[3:1]}, giving 0111, 1011, 1101, 1110, 0111...
  - Recovery: if column does not hold exactly one zero at a tick, it reloads 4'b0111.
- Indices:
  - col_idx = bit position of the zero in column (0111 -> 3).
  - row_idx = bit position of a zero in the sampled rows.
- Frame: four ticks, sampling columns idx 3,2,1,0 in that order. The frame completes at the tick that samples idx 0.
  - Per-frame accumulator records pressed-position count (saturating at 2) and the code of a pressed position.
  - Result = NONE (0 positions), SINGLE(code) (1 position), MULTI (2 or more, including two rows in one column).
  - Accumulator clears for the next frame.
- multi_key updates at every frame end: 1 iff result==MULTI.
- FSM, evaluated only at frame end. cnt is the frame counter; cand is the candidate code.
  - IDLE:
    - SINGLE(c) -> cand=c, cnt=1. If DEBOUNCE==1, accept immediately as in DEBOUNCE; otherwise go to DEBOUNCE.
    - NONE or MULTI -> stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE: go to PRESSED, key_code=cand, key_down=1, key_valid=1 for exactly the next clock cycle.
    - SINGLE(other) -> cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED:
    - SINGLE(key_code) or MULTI -> stay.
    - NONE -> RELEASE, cnt=1. If DEBOUNCE==1, go straight to IDLE with key_down=0.
    - SINGLE(other) -> RELEASE, cnt=0.
  - RELEASE:
    - NONE -> cnt++. At cnt==DEBOUNCE go to IDLE, key_down=0.
    - SINGLE(key_code) -> PRESSED with no new pulse.
    - Other -> cnt=0, stay.
- key_code holds its value after release until the next accepted press.
- Latency: a key stable from a frame start produces key_valid DEBOUNCE*4*TICK_DIV cycles later (±1 frame for mid-frame onset, plus 2 synchronizer cycles).
- Reset mid-operation: any state is abandoned and no key_valid is emitted. A partial frame in progress is discarded.
- cnt width: clog2(DEBOUNCE+1); it never exceeds DEBOUNCE.

Decomposition:
- Shared package keypad_pkg:
  - FSM state encoding (IDLE, DEBOUNCE, PRESSED, RELEASE).
  - Frame-result encoding (NONE, SINGLE, MULTI).
  - COLUMN_RESET=4'b0111.
- One sub-module: scan_tick_generator (prescaler, parameter TICK_DIV, outputs tick). The same tick generator also serves the display multiplexer.

Test Plan (TICK_DIV=4, DEBOUNCE=3, bench keypad model pulls row low when the matching column is low):
- Reset, then 16 cycles idle -> column steps 0111,1011,1101,1110,0111 every 4 cycles; all outputs 0.
- Press key col 2 / row 1, held 5 frames -> exactly one key_valid pulse at the end of frame 3; key_code=4'h9; key_down=1 from the same cycle.
- Bounce: press 2 frames, release 1 frame, press 4 frames -> no pulse after the first burst; one pulse at the end of the 3rd consecutive pressed frame.
- Keys (3,0) and (0,2) held together 4 frames -> multi_key=1 after frame 1; key_valid never pulses; key_down stays 0.
- After an accepted press of 4'h9: release 2 frames, re-press 1 frame, then release 3 frames -> no second key_valid; key_down falls only after the 3rd consecutive NONE frame; key_code stays 4'h9.
- reset=0 for one cycle during DEBOUNCE (cnt=2) -> no key_valid; column=0111 on the next cycle; the held key is then re-accepted 3 full frames later.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Scanner FSM states, per-frame result codes and active-low vector helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } frame_res_e;

  localparam logic [3:0] COLUMN_RESET = 4'b0111;

  // Lowest bit position holding a zero; 3 when only bit 3 (or nothing) is low.
  function automatic logic [1:0] zero_index(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0]) begin
      idx = 2'd0;
    end else if (!v[1]) begin
      idx = 2'd1;
    end else if (!v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [1:0] zero_count_sat(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~v[i]};
    end
    return (n >= 3'd2) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic one_cold(input logic [3:0] v);
    return (v == 4'b0111) || (v == 4'b1011) || (v == 4'b1101) || (v == 4'b1110);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the scanner and its consumer.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;

  modport master (
    input  row,
    output column, key_code, key_valid, key_down, multi_key
  );

  modport slave (
    output row,
    input  column, key_code, key_valid, key_down, multi_key
  );
endinterface

// File: rtl/scan_tick_generator.sv
// Free-running prescaler giving a one-cycle step strobe every TICK_DIV clocks.
// Shared by the keypad scanner and the display digit multiplexer.
module scan_tick_generator #(
  parameter int TICK_DIV = 65536
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;

  assign tick = (count_r == LAST);

  // Prescaler wraps to zero on the strobe cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (tick) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1);
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, row sampling per step,
// whole-frame debounce of a single key with multi-key detection.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int TICK_DIV = 65536,
  parameter int DEBOUNCE = 4
) (
  input  logic              clock,
  input  logic              reset,
  keypad_scanner_if.master  kp
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic            tick_s;
  logic [3:0]      sync1_r, sync2_r;
  logic [3:0]      column_r, column_s;
  logic [1:0]      acc_cnt_r, acc_cnt_s;
  logic [3:0]      acc_code_r, acc_code_s;
  logic [1:0]      col_idx_s, row_idx_s, row_hits_s, sum_sat_s;
  logic [2:0]      sum_s;
  logic [3:0]      frame_code_s;
  logic            col_ok_s, frame_end_s;
  frame_res_e      res_s;
  kp_state_e       state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [3:0]      cand_r, cand_s;
  logic [3:0]      key_code_r, key_code_s;
  logic            key_down_r, key_down_s;
  logic            key_valid_r, key_valid_s;
  logic            multi_r, multi_s;

  scan_tick_generator #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s)
  );

  // Two-flop synchronizer on the asynchronous row pins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_r <= 4'hF;
      sync2_r <= 4'hF;
    end else begin
      sync1_r <= kp.row;
      sync2_r <= sync1_r;
    end
  end

  // Column stepping and per-frame accumulation of pressed positions.
  always_comb begin
    col_ok_s     = one_cold(column_r);
    col_idx_s    = zero_index(column_r);
    row_idx_s    = zero_index(sync2_r);
    row_hits_s   = col_ok_s ? zero_count_sat(sync2_r) : 2'd0;
    sum_s        = {1'b0, acc_cnt_r} + {1'b0, row_hits_s};
    sum_sat_s    = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    frame_end_s  = tick_s && (column_r == 4'b1110);
    column_s     = column_r;
    acc_cnt_s    = acc_cnt_r;
    acc_code_s   = acc_code_r;
    frame_code_s = acc_code_r;
    if ((acc_cnt_r == 2'd0) && (row_hits_s != 2'd0)) begin
      frame_code_s = {col_idx_s, row_idx_s};
    end else begin
      frame_code_s = acc_code_r;
    end
    case (sum_sat_s)
      2'd0:    res_s = RES_NONE;
      2'd1:    res_s = RES_SINGLE;
      default: res_s = RES_MULTI;
    endcase
    if (tick_s) begin
      column_s = col_ok_s ? {column_r[0], column_r[3:1]} : COLUMN_RESET;
      if (frame_end_s) begin
        acc_cnt_s  = 2'd0;
        acc_code_s = 4'h0;
      end else begin
        acc_cnt_s  = sum_sat_s;
        acc_code_s = frame_code_s;
      end
    end else begin
      column_s = column_r;
    end
  end

  // Debounce FSM, advanced only when a frame completes.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cand_s      = cand_r;
    key_code_s  = key_code_r;
    key_down_s  = key_down_r;
    key_valid_s = 1'b0;
    multi_s     = multi_r;
    if (frame_end_s) begin
      multi_s = (res_s == RES_MULTI);
      case (state_r)
        ST_IDLE: begin
          if (res_s == RES_SINGLE) begin
            cand_s = frame_code_s;
            cnt_s  = CNT_ONE;
            if (DEBOUNCE == 1) begin
              state_s     = ST_PRESSED;
              key_code_s  = frame_code_s;
              key_down_s  = 1'b1;
              key_valid_s = 1'b1;
            end else begin
              state_s = ST_DEBOUNCE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if ((res_s == RES_SINGLE) && (frame_code_s == cand_r)) begin
            cnt_s = cnt_r + CNT_ONE;
            if ((cnt_r + CNT_ONE) == CNT_MAX) begin
              state_s     = ST_PRESSED;
              key_code_s  = cand_r;
              key_down_s  = 1'b1;
              key_valid_s = 1'b1;
            end else begin
              state_s = ST_DEBOUNCE;
            end
          end else if (res_s == RES_SINGLE) begin
            cand_s = frame_code_s;
            cnt_s  = CNT_ONE;
          end else begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
          end
        end
        ST_PRESSED: begin
          if (res_s == RES_NONE) begin
            cnt_s = CNT_ONE;
            if (DEBOUNCE == 1) begin
              state_s    = ST_IDLE;
              key_down_s = 1'b0;
            end else begin
              state_s = ST_RELEASE;
            end
          end else if ((res_s == RES_SINGLE) && (frame_code_s != key_code_r)) begin
            state_s = ST_RELEASE;
            cnt_s   = {CW{1'b0}};
          end else begin
            state_s = ST_PRESSED;
          end
        end
        ST_RELEASE: begin
          if (res_s == RES_NONE) begin
            cnt_s = cnt_r + CNT_ONE;
            if ((cnt_r + CNT_ONE) == CNT_MAX) begin
              state_s    = ST_IDLE;
              key_down_s = 1'b0;
              cnt_s      = {CW{1'b0}};
            end else begin
              state_s = ST_RELEASE;
            end
          end else if ((res_s == RES_SINGLE) && (frame_code_s == key_code_r)) begin
            state_s = ST_PRESSED;
          end else begin
            cnt_s = {CW{1'b0}};
          end
        end
        default: begin
          state_s    = ST_IDLE;
          cnt_s      = {CW{1'b0}};
          key_down_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      column_r    <= COLUMN_RESET;
      acc_cnt_r   <= 2'd0;
      acc_code_r  <= 4'h0;
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      cand_r      <= 4'h0;
      key_code_r  <= 4'h0;
      key_down_r  <= 1'b0;
      key_valid_r <= 1'b0;
      multi_r     <= 1'b0;
    end else begin
      column_r    <= column_s;
      acc_cnt_r   <= acc_cnt_s;
      acc_code_r  <= acc_code_s;
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cand_r      <= cand_s;
      key_code_r  <= key_code_s;
      key_down_r  <= key_down_s;
      key_valid_r <= key_valid_s;
      multi_r     <= multi_s;
    end
  end

  assign kp.column    = column_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_down  = key_down_r;
  assign kp.multi_key = multi_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level reference model plus directed key scenarios.
module tb_keypad_scanner;
  localparam int TD  = 4;
  localparam int DEB = 3;
  localparam int M_IDLE = 0, M_DEB = 1, M_PRS = 2, M_REL = 3;

  typedef struct {
    int         phase;
    int         frames;
    int         mode;
    int         cnt;
    logic [3:0] column;
    logic [3:0] cand;
    logic [3:0] code;
    logic       down;
    logic       valid;
    logic       multi;
  } model_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic [3:0]  rows_s;
  model_t      m;
  int          n_checks = 0;
  int          n_pass = 0;
  int          pulses = 0;
  bit          checking = 1'b0;

  keypad_scanner_if bus ();

  keypad_scanner #(.TICK_DIV(TD), .DEBOUNCE(DEB)) dut (
    .clock (clock),
    .reset (reset),
    .kp    (bus.master)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows_s = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4 + r] && (bus.column[c] == 1'b0)) rows_s[r] = 1'b0;
      end
    end
  end
  assign bus.row = rows_s;

  function automatic model_t model_step(model_t mi, logic rst, logic [15:0] k);
    model_t n;
    int pos, idx;
    logic [3:0] code;
    bit accept;
    n = mi;
    n.valid = 1'b0;
    accept = 1'b0;
    if (rst !== 1'b1) begin
      n.phase = 0; n.column = 4'b0111; n.code = 4'h0; n.down = 1'b0;
      n.multi = 1'b0; n.mode = M_IDLE; n.cnt = 0; n.cand = 4'h0;
      return n;
    end
    if (mi.phase % TD == TD - 1) begin
      idx = 3 - ((mi.phase + 1) % (4 * TD)) / TD;
      n.column = 4'hF ^ (4'h1 << idx);
      if (mi.phase == 4 * TD - 1) begin
        n.frames = mi.frames + 1;
        pos = $countones(k);
        code = 4'h0;
        for (int i = 0; i < 16; i++) if (k[i]) code = 4'(i);
        n.multi = (pos >= 2);
        case (mi.mode)
          M_IDLE: if (pos == 1) begin
            n.cand = code; n.cnt = 1;
            if (n.cnt == DEB) accept = 1'b1; else n.mode = M_DEB;
          end
          M_DEB: if (pos == 1 && code == mi.cand) begin
            n.cnt = mi.cnt + 1;
            if (n.cnt == DEB) accept = 1'b1;
          end else if (pos == 1) begin
            n.cand = code; n.cnt = 1;
          end else begin
            n.mode = M_IDLE; n.cnt = 0;
          end
          M_PRS: if (pos == 0) begin
            n.cnt = 1;
            if (DEB == 1) begin n.mode = M_IDLE; n.down = 1'b0; end
            else n.mode = M_REL;
          end else if (pos == 1 && code != mi.code) begin
            n.mode = M_REL; n.cnt = 0;
          end
          default: if (pos == 0) begin
            n.cnt = mi.cnt + 1;
            if (n.cnt == DEB) begin n.mode = M_IDLE; n.down = 1'b0; n.cnt = 0; end
          end else if (pos == 1 && code == mi.code) begin
            n.mode = M_PRS;
          end else begin
            n.cnt = 0;
          end
        endcase
        if (accept) begin
          n.mode = M_PRS; n.code = n.cand; n.down = 1'b1; n.valid = 1'b1;
        end
      end
    end
    n.phase = (mi.phase + 1) % (4 * TD);
    return n;
  endfunction

  always @(posedge clock) m <= model_step(m, reset, keys);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // One clock: sample at the falling edge, compare every output with the model.
  task automatic step();
    @(negedge clock);
    if (bus.key_valid === 1'b1) pulses++;
    if (checking) begin
      chk("cyc_column",    32'(bus.column),    32'(m.column));
      chk("cyc_key_code",  32'(bus.key_code),  32'(m.code));
      chk("cyc_key_valid", 32'(bus.key_valid), 32'(m.valid));
      chk("cyc_key_down",  32'(bus.key_down),  32'(m.down));
      chk("cyc_multi_key", 32'(bus.multi_key), 32'(m.multi));
    end
  endtask

  task automatic run_frames(input int n);
    int target, guard;
    target = m.frames + n;
    guard = 0;
    while (m.frames < target && guard < n * 4 * TD + 8) begin
      step();
      guard++;
    end
    chk("frame_wait", 32'(m.frames >= target), 32'd1);
  endtask

  initial begin
    int p0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("rst_column", 32'(bus.column), 32'h7);
    chk("rst_key_code", 32'(bus.key_code), 32'h0);
    chk("rst_key_valid", 32'(bus.key_valid), 32'h0);
    chk("rst_key_down", 32'(bus.key_down), 32'h0);
    chk("rst_multi_key", 32'(bus.multi_key), 32'h0);
    checking = 1'b1;

    repeat (4) step();
    chk("idle_col_step1", 32'(bus.column), 32'hB);
    run_frames(1);

    // Single key (col 2, row 1) held 5 frames.
    p0 = pulses;
    keys = 16'h0200;
    run_frames(3);
    chk("press_valid", 32'(bus.key_valid), 32'h1);
    chk("press_down", 32'(bus.key_down), 32'h1);
    chk("press_code", 32'(bus.key_code), 32'h9);
    run_frames(2);
    chk("press_pulses", 32'(pulses - p0), 32'd1);
    keys = 16'h0000;
    run_frames(3);
    chk("release_down", 32'(bus.key_down), 32'h0);

    // Bounce on key (1,2): 2 pressed, 1 released, 4 pressed.
    p0 = pulses;
    keys = 16'h0040;
    run_frames(2);
    keys = 16'h0000;
    run_frames(1);
    chk("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    keys = 16'h0040;
    run_frames(3);
    chk("bounce_valid", 32'(bus.key_valid), 32'h1);
    chk("bounce_code", 32'(bus.key_code), 32'h6);
    run_frames(1);
    chk("bounce_pulses", 32'(pulses - p0), 32'd1);
    keys = 16'h0000;
    run_frames(3);

    // Two keys (3,0) and (0,2) held together.
    p0 = pulses;
    keys = 16'h1004;
    run_frames(1);
    chk("multi_set", 32'(bus.multi_key), 32'h1);
    run_frames(3);
    chk("multi_pulses", 32'(pulses - p0), 32'd0);
    chk("multi_down", 32'(bus.key_down), 32'h0);
    keys = 16'h0000;
    run_frames(1);
    chk("multi_clear", 32'(bus.multi_key), 32'h0);

    // Accept 9, then release 2 / re-press 1 / release 3.
    keys = 16'h0200;
    run_frames(3);
    chk("rel_accept", 32'(bus.key_valid), 32'h1);
    p0 = pulses;
    keys = 16'h0000;
    run_frames(2);
    keys = 16'h0200;
    run_frames(1);
    keys = 16'h0000;
    run_frames(2);
    chk("rel_down_held", 32'(bus.key_down), 32'h1);
    run_frames(1);
    chk("rel_down_fall", 32'(bus.key_down), 32'h0);
    chk("rel_code_kept", 32'(bus.key_code), 32'h9);
    chk("rel_no_pulse", 32'(pulses - p0), 32'd0);

    // Reset pulse while debouncing key (1,1) at cnt=2.
    p0 = pulses;
    keys = 16'h0020;
    run_frames(2);
    repeat (5) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_column", 32'(bus.column), 32'h7);
    chk("midrst_no_pulse", 32'(pulses - p0), 32'd0);
    run_frames(2);
    chk("midrst_not_yet", 32'(pulses - p0), 32'd0);
    run_frames(1);
    chk("midrst_valid", 32'(bus.key_valid), 32'h1);
    chk("midrst_code", 32'(bus.key_code), 32'h5);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
